// File: rtl/csa_pkg.sv
// Shared defaults, counter width and state encoding
// for the carry-save stream accumulator.
package csa_pkg;

   localparam int DEF_WIDTH     = 16;
   localparam int DEF_NUM_OPS   = 9;
   localparam int DEF_OUT_WIDTH = 20;
   localparam int CNT_W         = $clog2(DEF_NUM_OPS + 1);

   typedef enum logic [1:0] {
      ACCUM,
      RESOLVE,
      DONE
   } state_t;

endpackage

// File: rtl/csa_compressor_3to2.sv
// One row of N full adders: three vectors in, sum and
// unshifted carry vectors out (parent does the shift).
module csa_compressor_3to2 #(
   parameter int N = 20
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] d,
   output logic [N-1:0] sum,
   output logic [N-1:0] carry
);

   assign sum   = a ^ b ^ d;
   assign carry = (a & b) | (a & d) | (b & d);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Serial multi-operand adder with carry-save state and one
// resolve add. Optional macro CSA_EARLY_LAST_EN adds in_last.
module csa_stream_accumulator
   import csa_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int NUM_OPS   = DEF_NUM_OPS,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
`ifdef CSA_EARLY_LAST_EN
   input  logic                 in_last,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_sum,
   output logic                 out_cout
);

   localparam int CW = $clog2(NUM_OPS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_OPS - 1);

   state_t               state;
   logic [OUT_WIDTH-1:0] s;
   logic [OUT_WIDTH-1:0] c;
   logic [OUT_WIDTH-1:0] x;
   logic [OUT_WIDTH-1:0] row_s;
   logic [OUT_WIDTH-1:0] row_c;
   logic [CW-1:0]        cnt;
   logic                 accept;
   logic                 last;

   assign x      = OUT_WIDTH'(in_data);
   assign accept = in_valid && in_ready;

`ifdef CSA_EARLY_LAST_EN
   assign last = (cnt == LAST_CNT) || in_last;
`else
   assign last = (cnt == LAST_CNT);
`endif

   csa_compressor_3to2 #(
      .N (OUT_WIDTH)
   ) u_row (
      .a     (s),
      .b     (c),
      .d     (x),
      .sum   (row_s),
      .carry (row_c)
   );

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         s         <= '0;
         c         <= '0;
         cnt       <= '0;
      end else begin
         unique case (state)
            ACCUM: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               if (accept) begin
                  s   <= row_s;
                  c   <= row_c << 1;
                  cnt <= cnt + 1'b1;
                  if (last) begin
                     state    <= RESOLVE;
                     in_ready <= 1'b0;
                  end
               end
            end
            RESOLVE: begin
               {out_cout, out_sum} <= {1'b0, s} + {1'b0, c};
               s         <= '0;
               c         <= '0;
               cnt       <= '0;
               in_ready  <= 1'b0;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ACCUM;
               end
            end
            default: begin
               state <= ACCUM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench: directed scenarios plus random
// groups against an integer-sum reference model.
module tb_csa_stream_accumulator;

   localparam int N  = 9;
   localparam int OW = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_sum;
   logic          out_cout;

   int     total  = 0;
   int     passed = 0;
   int     failed = 0;
   longint model_sum = 0;
   int     model_cnt = 0;

   always #5 clk = ~clk;

   csa_stream_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef CSA_EARLY_LAST_EN
      .in_last   (in_last),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
   );

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] x, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = x;
      in_last  = last;
      while (in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", in_ready, 1);
      @(posedge clk);
      model_sum += longint'(x);
      model_cnt++;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_result(input string tag, input int hold);
      int n;
      logic [63:0] es;
      n  = 0;
      es = 64'(model_sum);
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_sum"}, out_sum, es[OW-1:0]);
      check({tag, "_cout"}, out_cout, es[OW]);
      check({tag, "_busy"}, in_ready, 0);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_data  = 16'($urandom);
         @(negedge clk);
         check({tag, "_hold_sum"}, out_sum, es[OW-1:0]);
         check({tag, "_hold_valid"}, out_valid, 1);
         check({tag, "_hold_busy"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_drop"}, out_valid, 0);
      check({tag, "_rearm"}, in_ready, 1);
      model_sum = 0;
      model_cnt = 0;
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_sum"}, out_sum, 0);
      check({tag, "_ready"}, in_ready, 0);
      @(negedge clk);
      check({tag, "_rearm"}, in_ready, 1);
      model_sum = 0;
      model_cnt = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_cout", out_cout, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_rise_ready", in_ready, 1);

      // back-to-back all-ones group, exact latency
      for (int i = 0; i < N; i++)
         send(16'hFFFF, 1'b0);
      check("s1_lat_k", out_valid, 0);
      @(negedge clk);
      check("s1_lat_k1", out_valid, 1);
      check("s1_const", out_sum, 20'h8FFF7);
      expect_result("s1", 0);

      // 1..9 with a bubble gap, then held result
      for (int i = 1; i <= N; i++) begin
         send(16'(i), 1'b0);
         if (i == 4) begin
            repeat (3) begin
               @(negedge clk);
               check("s2_gap_ready", in_ready, 1);
               check("s2_gap_valid", out_valid, 0);
            end
         end
      end
      check("s2_model", 64'(model_sum), 45);
      expect_result("s3", 5);

      for (int i = 0; i < N; i++)
         send(16'h0000, 1'b0);
      expect_result("s3_zero", 0);

      // reset in the middle of a group
      for (int i = 0; i < 5; i++)
         send(16'h1000, 1'b0);
      pulse_reset("s4_rst");
      for (int i = 0; i < N; i++) begin
         send(16'h0001, 1'b0);
         if (i < N - 1)
            check("s4_no_valid", out_valid, 0);
      end
      expect_result("s4", 0);

      // reset while a result is pending
      for (int i = 1; i <= N; i++)
         send(16'(i), 1'b0);
      @(negedge clk);
      check("s5_valid", out_valid, 1);
      check("s5_sum", out_sum, 45);
      pulse_reset("s5_rst");

`ifdef CSA_EARLY_LAST_EN
      send(16'h00FF, 1'b0);
      send(16'h0F00, 1'b0);
      send(16'h1000, 1'b1);
      check("s6_lat_k", out_valid, 0);
      @(negedge clk);
      check("s6_lat_k1", out_valid, 1);
      check("s6_const", out_sum, 20'h01FFF);
      expect_result("s6", 0);
      send(16'hABCD, 1'b1);
      expect_result("s6_single", 0);
`else
      send(16'h00FF, 1'b0);
      send(16'h0F00, 1'b0);
      send(16'h1000, 1'b1);
      repeat (5) begin
         @(negedge clk);
         check("s6_no_valid", out_valid, 0);
      end
      pulse_reset("s6_rst");
`endif

      // random groups with bubbles and back-pressure
      for (int g = 0; g < 20; g++) begin
         for (int k = 0; k < N; k++) begin
            logic lst;
`ifdef CSA_EARLY_LAST_EN
            lst = ($urandom_range(0, 5) == 0);
`else
            lst = 1'b0;
`endif
            send(16'($urandom), lst);
            if (lst || model_cnt == N)
               break;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         expect_result("rnd", int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
